nand_tree_pipe: RTL and testbench

- Parametrised, pipelined wide reduction gate; successor to the fixed 4-input NAND cell.
- Reduces a WIDTH-bit vector with RADIX-input gates per level and registers every level.
- Selects NAND/AND/NOR/OR per sample, with a valid flag and stall enable.
- Used where wide decodes and compares, too deep for one cycle, feed clocked logic built from the mcu9t3v3 cells.

---
 rtl/nand_tree_pkg.sv | 29 ++
 rtl/nand_tree_level.sv | 55 +++++
 rtl/nand_tree_pipe.sv | 76 +++++++
 tb/tb_nand_tree_pipe.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/nand_tree_pkg.sv
// Shared constants and elaboration helpers for the pipelined reduction tree.
package nand_tree_pkg;

  localparam logic [1:0] MODE_NAND = 2'b00;
  localparam logic [1:0] MODE_AND  = 2'b01;
  localparam logic [1:0] MODE_NOR  = 2'b10;
  localparam logic [1:0] MODE_OR   = 2'b11;

  // Number of RADIX-input levels needed to reduce WIDTH bits to one.
  function automatic int clog_radix(input int width, input int radix);
    int levels;
    int cap;
    levels = 0;
    cap    = 1;
    for (int k = 0; k < 32; k++) begin
      if (cap < width) begin
        cap    = cap * radix;
        levels = levels + 1;
      end
    end
    return levels;
  endfunction

  // Identity element of the mode's family: 1 for AND/NAND, 0 for OR/NOR.
  function automatic logic ident(input logic [1:0] mode);
    return (mode == MODE_NAND) || (mode == MODE_AND);
  endfunction

endpackage

// File: rtl/nand_tree_level.sv
// One reduction level: RADIX-wise AND/OR of its input, then registered
// together with the sample's valid flag and mode. The final level only
// reloads data/mode on a valid sample so the output holds its last result.
module nand_tree_level
  import nand_tree_pkg::*;
#(
  parameter int WIDTH_IN = 16,
  parameter int RADIX    = 4,
  parameter bit FINAL    = 1'b0
) (
  input  logic                      ck,
  input  logic                      nrst,
  input  logic                      en_i,
  input  logic [WIDTH_IN-1:0]       data_i,
  input  logic                      valid_i,
  input  logic [1:0]                mode_i,
  output logic [WIDTH_IN/RADIX-1:0] data_o,
  output logic                      valid_o,
  output logic [1:0]                mode_o
);

  localparam int WIDTH_OUT = WIDTH_IN / RADIX;

  logic [WIDTH_OUT-1:0] red_d;
  logic [WIDTH_OUT-1:0] data_q;
  logic                 valid_q;
  logic [1:0]           mode_q;

  // Each output lane reduces its own RADIX-bit group; mode[1] picks the family.
  genvar gi;
  for (gi = 0; gi < WIDTH_OUT; gi++) begin : g_gate
    assign red_d[gi] = mode_i[1] ? (|data_i[gi*RADIX +: RADIX])
                                 : (&data_i[gi*RADIX +: RADIX]);
  end

  // Stage register: reset to the AND-family identity, hold whenever en_i is low.
  always_ff @(posedge ck or negedge nrst) begin
    if (!nrst) begin
      data_q  <= '1;
      valid_q <= 1'b0;
      mode_q  <= MODE_AND;
    end else if (en_i) begin
      valid_q <= valid_i;
      if (!FINAL || valid_i) begin
        data_q <= red_d;
        mode_q <= mode_i;
      end
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign mode_o  = mode_q;

endmodule

// File: rtl/nand_tree_pipe.sv
// Pipelined wide NAND/AND/NOR/OR reduction. The input is padded with the
// family identity to RADIX**LEVELS bits, reduced through LEVELS registered
// levels, and inverted after the last register for NAND/NOR.
module nand_tree_pipe
  import nand_tree_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int RADIX = 4
) (
  input  logic             ck,
  input  logic             nrst,
  input  logic             en,
  input  logic             iv,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] i,
  output logic             nq,
  output logic             ov
);

  localparam int LEVELS = clog_radix(WIDTH, RADIX);
  localparam int PAD_W  = RADIX ** LEVELS;
  localparam int LAST   = LEVELS - 1;

  logic [PAD_W-1:0] pad_d;

  // Fill unused lanes with the identity so padding never affects the result.
  always_comb begin
    pad_d            = {PAD_W{ident(mode)}};
    pad_d[WIDTH-1:0] = i;
  end

  genvar gi;
  for (gi = 0; gi < LEVELS; gi++) begin : g_lvl
    localparam int W_IN  = RADIX ** (LEVELS - gi);
    localparam int W_OUT = W_IN / RADIX;

    logic [W_IN-1:0]  d_in;
    logic             v_in;
    logic [1:0]       m_in;
    logic [W_OUT-1:0] d_out;
    logic             v_out;
    logic [1:0]       m_out;

    if (gi == 0) begin : g_head
      assign d_in = pad_d;
      assign v_in = iv;
      assign m_in = mode;
    end else begin : g_tail
      assign d_in = g_lvl[gi-1].d_out;
      assign v_in = g_lvl[gi-1].v_out;
      assign m_in = g_lvl[gi-1].m_out;
    end

    nand_tree_level #(
      .WIDTH_IN (W_IN),
      .RADIX    (RADIX),
      .FINAL    (gi == LAST)
    ) u_level (
      .ck      (ck),
      .nrst    (nrst),
      .en_i    (en),
      .data_i  (d_in),
      .valid_i (v_in),
      .mode_i  (m_in),
      .data_o  (d_out),
      .valid_o (v_out),
      .mode_o  (m_out)
    );
  end

  // Inversion happens only here; the held final data/mode keep nq stable.
  assign nq = g_lvl[LAST].d_out[0] ^ ((g_lvl[LAST].m_out == MODE_NAND) ||
                                      (g_lvl[LAST].m_out == MODE_NOR));
  assign ov = g_lvl[LAST].v_out;

endmodule

// File: tb/tb_nand_tree_pipe.sv
// Directed bench for nand_tree_pipe: a 16-bit/radix-4 instance for the main
// scenarios and a 10-bit/radix-4 instance for padding.
module tb_nand_tree_pipe;
  import nand_tree_pkg::*;

  logic        ck;
  logic        nrst;
  logic        en;
  logic        iv;
  logic [1:0]  mode;
  logic [15:0] i16;
  logic [9:0]  i10;
  logic        nq16, ov16;
  logic        nq10, ov10;

  int checks = 0;
  int errors = 0;

  nand_tree_pipe #(.WIDTH(16), .RADIX(4)) dut (
    .ck(ck), .nrst(nrst), .en(en), .iv(iv), .mode(mode), .i(i16),
    .nq(nq16), .ov(ov16)
  );

  nand_tree_pipe #(.WIDTH(10), .RADIX(4)) dut_p (
    .ck(ck), .nrst(nrst), .en(en), .iv(iv), .mode(mode), .i(i10),
    .nq(nq10), .ov(ov10)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  task automatic step();
    @(posedge ck);
    #1;
  endtask

  task automatic drive(input logic [15:0] d, input logic [1:0] m, input logic v);
    i16  = d;
    mode = m;
    iv   = v;
  endtask

  task automatic test_reset();
    nrst = 1'b0; en = 1'b1; i10 = 10'h3FF;
    drive(16'hFFFF, MODE_NAND, 1'b1);
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if ({nq16, ov16} !== 2'b10) begin
        errors++;
        $display("FAIL reset_hold16 cyc %0d: nq/ov=%b%b expected 10", c, nq16, ov16);
      end else $display("txn reset_hold16 cyc %0d nq=%b ov=%b", c, nq16, ov16);
      checks++;
      if ({nq10, ov10} !== 2'b10) begin
        errors++;
        $display("FAIL reset_hold10 cyc %0d: nq/ov=%b%b expected 10", c, nq10, ov10);
      end else $display("txn reset_hold10 cyc %0d nq=%b ov=%b", c, nq10, ov10);
    end
    nrst = 1'b1;
    drive(16'hFFFF, MODE_NAND, 1'b0);
    for (int c = 0; c < 4; c++) begin
      step();
      checks++;
      if ({nq16, ov16} !== 2'b10) begin
        errors++;
        $display("FAIL reset_release cyc %0d: nq/ov=%b%b expected 10", c, nq16, ov16);
      end else $display("txn reset_release cyc %0d nq=%b ov=%b", c, nq16, ov16);
    end
  endtask

  task automatic test_nand_basic();
    drive(16'hFFFF, MODE_NAND, 1'b1);
    step();
    checks++;
    if (ov16 !== 1'b0) begin
      errors++;
      $display("FAIL nand_latency: ov=%b expected 0 after first edge", ov16);
    end else $display("txn nand_latency ov=%b", ov16);
    drive(16'hFFFE, MODE_NAND, 1'b1);
    step();
    checks++;
    if ({nq16, ov16} !== 2'b01) begin
      errors++;
      $display("FAIL nand_ffff: nq/ov=%b%b expected 01", nq16, ov16);
    end else $display("txn nand_ffff nq=%b ov=%b", nq16, ov16);
    drive(16'h0000, MODE_NAND, 1'b0);
    step();
    checks++;
    if ({nq16, ov16} !== 2'b11) begin
      errors++;
      $display("FAIL nand_fffe: nq/ov=%b%b expected 11", nq16, ov16);
    end else $display("txn nand_fffe nq=%b ov=%b", nq16, ov16);
    step();
    checks++;
    if ({nq16, ov16} !== 2'b10) begin
      errors++;
      $display("FAIL nand_hold: nq/ov=%b%b expected 10", nq16, ov16);
    end else $display("txn nand_hold nq=%b ov=%b", nq16, ov16);
  endtask

  task automatic test_back_to_back();
    logic [15:0] vec [4];
    logic [1:0]  md  [4];
    logic        exp_nq [4];
    vec[0] = 16'hFFFF; md[0] = MODE_AND;  exp_nq[0] = 1'b1;
    vec[1] = 16'h0000; md[1] = MODE_NOR;  exp_nq[1] = 1'b1;
    vec[2] = 16'h0000; md[2] = MODE_OR;   exp_nq[2] = 1'b0;
    vec[3] = 16'h0010; md[3] = MODE_NAND; exp_nq[3] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k < 4) drive(vec[k], md[k], 1'b1);
      else       drive(16'h0000, MODE_NAND, 1'b0);
      step();
      if (k >= 1) begin
        checks++;
        if ({nq16, ov16} !== {exp_nq[k-1], 1'b1}) begin
          errors++;
          $display("FAIL b2b sample %0d: nq/ov=%b%b expected %b1", k-1, nq16, ov16, exp_nq[k-1]);
        end else $display("txn b2b sample %0d nq=%b ov=%b", k-1, nq16, ov16);
      end
    end
    step();
    checks++;
    if ({nq16, ov16} !== 2'b10) begin
      errors++;
      $display("FAIL b2b_drain: nq/ov=%b%b expected 10", nq16, ov16);
    end else $display("txn b2b_drain nq=%b ov=%b", nq16, ov16);
  endtask

  task automatic test_stall();
    drive(16'hFFFF, MODE_NAND, 1'b1);
    step();
    en = 1'b0;
    drive(16'h0000, MODE_OR, 1'b1);
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if ({nq16, ov16} !== 2'b10) begin
        errors++;
        $display("FAIL stall_frozen cyc %0d: nq/ov=%b%b expected 10", c, nq16, ov16);
      end else $display("txn stall_frozen cyc %0d nq=%b ov=%b", c, nq16, ov16);
    end
    en = 1'b1;
    drive(16'h0000, MODE_NAND, 1'b0);
    step();
    checks++;
    if ({nq16, ov16} !== 2'b01) begin
      errors++;
      $display("FAIL stall_result: nq/ov=%b%b expected 01", nq16, ov16);
    end else $display("txn stall_result nq=%b ov=%b", nq16, ov16);
    step();
    checks++;
    if ({nq16, ov16} !== 2'b00) begin
      errors++;
      $display("FAIL stall_ignored: nq/ov=%b%b expected 00", nq16, ov16);
    end else $display("txn stall_ignored nq=%b ov=%b", nq16, ov16);
  endtask

  task automatic test_padding();
    logic [9:0] vec [4];
    logic [1:0] md  [4];
    logic       exp_nq [4];
    vec[0] = 10'h3FF; md[0] = MODE_NAND; exp_nq[0] = 1'b0;
    vec[1] = 10'h000; md[1] = MODE_NOR;  exp_nq[1] = 1'b1;
    vec[2] = 10'h200; md[2] = MODE_OR;   exp_nq[2] = 1'b1;
    vec[3] = 10'h1FF; md[3] = MODE_AND;  exp_nq[3] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k < 4) begin
        i10 = vec[k];
        drive(16'h0000, md[k], 1'b1);
      end else begin
        drive(16'h0000, MODE_NAND, 1'b0);
      end
      step();
      if (k >= 1) begin
        checks++;
        if ({nq10, ov10} !== {exp_nq[k-1], 1'b1}) begin
          errors++;
          $display("FAIL pad sample %0d: nq/ov=%b%b expected %b1", k-1, nq10, ov10, exp_nq[k-1]);
        end else $display("txn pad sample %0d nq=%b ov=%b", k-1, nq10, ov10);
      end
    end
  endtask

  task automatic test_mid_reset();
    drive(16'hFFFF, MODE_NAND, 1'b1);
    step();
    drive(16'hFFFF, MODE_NAND, 1'b1);
    step();
    checks++;
    if ({nq16, ov16} !== 2'b01) begin
      errors++;
      $display("FAIL midrst_before: nq/ov=%b%b expected 01", nq16, ov16);
    end else $display("txn midrst_before nq=%b ov=%b", nq16, ov16);
    drive(16'h0000, MODE_NAND, 1'b0);
    #1 nrst = 1'b0;
    #1;
    checks++;
    if ({nq16, ov16} !== 2'b10) begin
      errors++;
      $display("FAIL midrst_async: nq/ov=%b%b expected 10", nq16, ov16);
    end else $display("txn midrst_async nq=%b ov=%b", nq16, ov16);
    #2 nrst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if ({nq16, ov16} !== 2'b10) begin
        errors++;
        $display("FAIL midrst_after cyc %0d: nq/ov=%b%b expected 10", c, nq16, ov16);
      end else $display("txn midrst_after cyc %0d nq=%b ov=%b", c, nq16, ov16);
    end
  endtask

  initial begin
    test_reset();
    test_nand_basic();
    test_back_to_back();
    test_stall();
    test_padding();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

endmodule
